// File: rtl/ysyx_25060170_wbu_pipe_pkg.sv
// Shared encodings for the write-back stage: source select, load funct3 and FSM states.
package ysyx_25060170_wbu_pipe_pkg;

  localparam int unsigned WB_SEL_W = 2;
  localparam int unsigned FMT_W    = 3;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  localparam logic [FMT_W-1:0] LF_LB  = 3'b000;
  localparam logic [FMT_W-1:0] LF_LH  = 3'b001;
  localparam logic [FMT_W-1:0] LF_LW  = 3'b010;
  localparam logic [FMT_W-1:0] LF_LBU = 3'b100;
  localparam logic [FMT_W-1:0] LF_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WB       = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_25060170_wbu_pipe_if.sv
// Bus bundle between EXU/LSU/IFU/GPR/difftest and the write-back stage.
interface ysyx_25060170_wbu_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_alu_result;
  logic [XLEN-1:0]   in_next_pc;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_we;
  logic [1:0]        in_wb_sel;
  logic [XLEN-1:0]   in_csr_rdata;
  logic [2:0]        in_load_fmt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc_next;
  logic              gpr_we;
  logic [REG_AW-1:0] gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic [CNT_W-1:0]  retire_cnt;
  logic              load_misalign;

  modport master (
    output in_valid, in_pc, in_alu_result, in_next_pc, in_rd, in_reg_we,
           in_wb_sel, in_csr_rdata, in_load_fmt, mem_rvalid, mem_rdata, out_ready,
    input  in_ready, out_valid, out_pc_next, gpr_we, gpr_waddr, gpr_wdata,
           commit_valid, commit_pc, retire_cnt, load_misalign
  );

  modport slave (
    input  in_valid, in_pc, in_alu_result, in_next_pc, in_rd, in_reg_we,
           in_wb_sel, in_csr_rdata, in_load_fmt, mem_rvalid, mem_rdata, out_ready,
    output in_ready, out_valid, out_pc_next, gpr_we, gpr_waddr, gpr_wdata,
           commit_valid, commit_pc, retire_cnt, load_misalign
  );
endinterface

// File: rtl/ysyx_25060170_load_fmt.sv
// Combinational load formatter: lane-shifts a word-aligned beat, extends it and flags misalignment.
module ysyx_25060170_load_fmt
  import ysyx_25060170_wbu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      addr_i,
  input  logic [2:0]      fmt_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_c_o,
  output logic            misalign_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = 8'(rdata_i >> {addr_i, 3'b000});
    half_sel     = 16'(rdata_i >> {addr_i, 3'b000});
    data_c_o     = '0;
    misalign_c_o = 1'b0;
    case (fmt_i)
      LF_LB:  data_c_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LF_LBU: data_c_o = {{(XLEN-8){1'b0}}, byte_sel};
      LF_LH: begin
        data_c_o     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign_c_o = addr_i[0];
      end
      LF_LHU: begin
        data_c_o     = {{(XLEN-16){1'b0}}, half_sel};
        misalign_c_o = addr_i[0];
      end
      LF_LW: begin
        data_c_o     = rdata_i;
        misalign_c_o = (addr_i != 2'b00);
      end
      default: data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_wbu_pipe.sv
// Handshaked write-back stage: captures a retiring instruction, waits for load data,
// writes the GPR once, commits, and offers the next PC to IFU.
module ysyx_25060170_wbu_pipe
  import ysyx_25060170_wbu_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     REG_AW   = 5,
  parameter int unsigned     CNT_W    = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_25060170_wbu_pipe_if.slave  bus
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_pc_next_q, out_pc_next_d;
  logic              gpr_we_q, gpr_we_d;
  logic [REG_AW-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [XLEN-1:0]   gpr_wdata_q, gpr_wdata_d;
  logic              commit_valid_q, commit_valid_d;
  logic [XLEN-1:0]   commit_pc_q, commit_pc_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              misalign_q, misalign_d;

  // Fields a load still needs after the handshake
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   next_pc_q, next_pc_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              reg_we_q, reg_we_d;
  logic [1:0]        addr_q, addr_d;
  logic [2:0]        fmt_q, fmt_d;

  logic [XLEN-1:0]   fmt_data;
  logic              fmt_misalign;
  logic [XLEN-1:0]   direct_data;

  ysyx_25060170_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .addr_i       (addr_q),
    .fmt_i        (fmt_q),
    .rdata_i      (bus.mem_rdata),
    .data_c_o     (fmt_data),
    .misalign_c_o (fmt_misalign)
  );

  // Write-back value for every source that needs no memory beat
  always_comb begin
    direct_data = '0;
    case (wb_sel_e'(bus.in_wb_sel))
      WB_ALU:  direct_data = bus.in_alu_result;
      WB_PC4:  direct_data = bus.in_pc + XLEN'(4);
      WB_CSR:  direct_data = bus.in_csr_rdata;
      default: direct_data = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    out_pc_next_d  = out_pc_next_q;
    gpr_we_d       = 1'b0;
    gpr_waddr_d    = gpr_waddr_q;
    gpr_wdata_d    = gpr_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    retire_cnt_d   = retire_cnt_q;
    misalign_d     = misalign_q;
    pc_d           = pc_q;
    next_pc_d      = next_pc_q;
    rd_d           = rd_q;
    reg_we_d       = reg_we_q;
    addr_d         = addr_q;
    fmt_d          = fmt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pc_d       = bus.in_pc;
          next_pc_d  = bus.in_next_pc;
          rd_d       = bus.in_rd;
          reg_we_d   = bus.in_reg_we;
          addr_d     = bus.in_alu_result[1:0];
          fmt_d      = bus.in_load_fmt;
          in_ready_d = 1'b0;
          if (wb_sel_e'(bus.in_wb_sel) == WB_MEM) begin
            state_d = WAIT_MEM;
          end else begin
            state_d        = WB;
            out_valid_d    = 1'b1;
            out_pc_next_d  = bus.in_next_pc;
            gpr_we_d       = bus.in_reg_we && (bus.in_rd != '0);
            gpr_waddr_d    = bus.in_rd;
            gpr_wdata_d    = direct_data;
            commit_valid_d = 1'b1;
            commit_pc_d    = bus.in_pc;
            retire_cnt_d   = retire_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d        = WB;
          out_valid_d    = 1'b1;
          out_pc_next_d  = next_pc_q;
          gpr_we_d       = reg_we_q && (rd_q != '0) && !fmt_misalign;
          gpr_waddr_d    = rd_q;
          gpr_wdata_d    = fmt_data;
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
          retire_cnt_d   = retire_cnt_q + CNT_W'(1);
          misalign_d     = misalign_q | fmt_misalign;
        end
      end
      WB: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_pc_next_q  <= RESET_PC;
      gpr_we_q       <= 1'b0;
      gpr_waddr_q    <= '0;
      gpr_wdata_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      retire_cnt_q   <= '0;
      misalign_q     <= 1'b0;
      pc_q           <= '0;
      next_pc_q      <= '0;
      rd_q           <= '0;
      reg_we_q       <= 1'b0;
      addr_q         <= '0;
      fmt_q          <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_pc_next_q  <= out_pc_next_d;
      gpr_we_q       <= gpr_we_d;
      gpr_waddr_q    <= gpr_waddr_d;
      gpr_wdata_q    <= gpr_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      retire_cnt_q   <= retire_cnt_d;
      misalign_q     <= misalign_d;
      pc_q           <= pc_d;
      next_pc_q      <= next_pc_d;
      rd_q           <= rd_d;
      reg_we_q       <= reg_we_d;
      addr_q         <= addr_d;
      fmt_q          <= fmt_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc_next   = out_pc_next_q;
  assign bus.gpr_we        = gpr_we_q;
  assign bus.gpr_waddr     = gpr_waddr_q;
  assign bus.gpr_wdata     = gpr_wdata_q;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_pc     = commit_pc_q;
  assign bus.retire_cnt    = retire_cnt_q;
  assign bus.load_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_25060170_wbu_pipe.sv
// Scoreboard bench for the write-back stage: stimulus pushes model results, a monitor
// pops them on every commit pulse and checks the GPR write, next PC and counters.
module tb_ysyx_25060170_wbu_pipe;
  import ysyx_25060170_wbu_pipe_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25060170_wbu_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  ysyx_25060170_wbu_pipe #(
    .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic bp_en    = 1'b0;
  logic or_force = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: what the architecture says a retiring instruction must write
  function automatic exp_t model(input logic [1:0] sel, input logic [31:0] alu, pc, npc, csr,
                                 input logic [4:0] rd, input logic we, input logic [2:0] fmt,
                                 input logic [31:0] rdata);
    exp_t e;
    int unsigned a;
    logic [31:0] w, b, h, d;
    a = alu % 4;
    w = rdata >> (8 * a);
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    d = 32'd0;
    e.mis = 1'b0;
    case (sel)
      2'd0: d = alu;
      2'd2: d = pc + 32'd4;
      2'd3: d = csr;
      default: begin
        case (fmt)
          3'b000: d = (b >= 32'd128) ? b - 32'd256 : b;
          3'b001: begin d = (h >= 32'h8000) ? h - 32'h10000 : h; e.mis = (a % 2) != 0; end
          3'b010: begin d = rdata; e.mis = (a != 0); end
          3'b100: d = b;
          3'b101: begin d = h; e.mis = (a % 2) != 0; end
          default: d = 32'd0;
        endcase
      end
    endcase
    e.pc = pc; e.npc = npc; e.rd = rd; e.wdata = d;
    e.we = we && (rd != 5'd0) && !e.mis;
    return e;
  endfunction

  // IFU backpressure: random when enabled, otherwise follows or_force
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = bp_en ? ($urandom_range(0, 3) != 0) : or_force;
    end
  end

  // Monitor: pops one expectation per commit pulse
  initial begin : monitor
    exp_t        e;
    logic        in_wb;
    logic [31:0] exp_npc;
    logic [63:0] cnt;
    logic        mis;
    in_wb = 1'b0; exp_npc = 32'd0; cnt = 64'd0; mis = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        in_wb = 1'b0; cnt = 64'd0; mis = 1'b0;
      end else begin
        if (!bus.commit_valid) chk("gpr_we_without_commit", 64'(bus.gpr_we), 64'd0);
        if (bus.commit_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_commit", 64'(bus.commit_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            cnt = cnt + 64'd1;
            mis = mis | e.mis;
            chk("commit_pc", 64'(bus.commit_pc), 64'(e.pc));
            chk("gpr_we", 64'(bus.gpr_we), 64'(e.we));
            if (e.we) begin
              chk("gpr_waddr", 64'(bus.gpr_waddr), 64'(e.rd));
              chk("gpr_wdata", 64'(bus.gpr_wdata), 64'(e.wdata));
            end
            chk("retire_cnt", bus.retire_cnt, cnt);
            chk("load_misalign", 64'(bus.load_misalign), 64'(mis));
          end
          in_wb   = 1'b1;
          exp_npc = e.npc;
        end
        if (in_wb) begin
          chk("out_valid_wb", 64'(bus.out_valid), 64'd1);
          chk("out_pc_next", 64'(bus.out_pc_next), 64'(exp_npc));
          if (bus.out_ready) in_wb = 1'b0;
        end else begin
          chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] sel, input logic [31:0] alu, pc, npc, csr,
                       input logic [4:0] rd, input logic we, input logic [2:0] fmt,
                       input logic [31:0] rdata, input int stall);
    int budget;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_wb_sel = sel; bus.in_alu_result = alu; bus.in_pc = pc;
    bus.in_next_pc = npc; bus.in_csr_rdata = csr; bus.in_rd = rd; bus.in_reg_we = we;
    bus.in_load_fmt = fmt;
    budget = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    exp_q.push_back(model(sel, alu, pc, npc, csr, rd, we, fmt, rdata));
    #2;
    // Scramble inputs so only captured values can produce the right answer
    bus.in_valid = 1'b0; bus.in_alu_result = $urandom(); bus.in_pc = $urandom();
    bus.in_next_pc = $urandom(); bus.in_csr_rdata = $urandom(); bus.in_rd = 5'($urandom());
    bus.in_load_fmt = 3'($urandom()); bus.in_wb_sel = 2'($urandom());
    if (sel == 2'd1) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_no_commit", 64'(bus.commit_valid), 64'd0);
        @(posedge clk); #2;
      end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
      @(posedge clk); #2;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom();
    end
    @(negedge clk);
    chk("commit_latency", 64'(bus.commit_valid), 64'd1);
  endtask

  initial begin : stim
    logic [2:0]  fmts [7];
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
    int          stall;
    fmts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_alu_result = '0; bus.in_next_pc = '0;
    bus.in_rd = '0; bus.in_reg_we = 1'b0; bus.in_wb_sel = '0; bus.in_csr_rdata = '0;
    bus.in_load_fmt = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc_next", 64'(bus.out_pc_next), 64'h8000_0000);
    chk("rst_gpr_we", 64'(bus.gpr_we), 64'd0);
    chk("rst_gpr_waddr", 64'(bus.gpr_waddr), 64'd0);
    chk("rst_gpr_wdata", 64'(bus.gpr_wdata), 64'd0);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_commit_pc", 64'(bus.commit_pc), 64'd0);
    chk("rst_retire_cnt", bus.retire_cnt, 64'd0);
    chk("rst_load_misalign", 64'(bus.load_misalign), 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // ALU write-back
    issue(2'd0, 32'h1234_5678, 32'h8000_0000, 32'h8000_0004, 32'd0, 5'd5, 1'b1, 3'b010, 32'd0, 0);
    chk("alu_wdata", 64'(bus.gpr_wdata), 64'h1234_5678);
    chk("alu_retire_cnt", bus.retire_cnt, 64'd1);
    // Byte loads at lane 2, stalled
    issue(2'd1, 32'h8000_0102, 32'h8000_0004, 32'h8000_0008, 32'd0, 5'd6, 1'b1, 3'b000, 32'h0080_FF00, 3);
    chk("lb_wdata", 64'(bus.gpr_wdata), 64'hFFFF_FF80);
    issue(2'd1, 32'h8000_0102, 32'h8000_0008, 32'h8000_000C, 32'd0, 5'd6, 1'b1, 3'b100, 32'h0080_FF00, 3);
    chk("lbu_wdata", 64'(bus.gpr_wdata), 64'h0000_0080);
    issue(2'd1, 32'h8000_0202, 32'h8000_000C, 32'h8000_0010, 32'd0, 5'd7, 1'b1, 3'b101, 32'hBEEF_0000, 1);
    chk("lhu_wdata", 64'(bus.gpr_wdata), 64'h0000_BEEF);
    // JAL to x0 and to x1, then a CSR read
    issue(2'd2, 32'd0, 32'h8000_000C, 32'h8000_0040, 32'd0, 5'd0, 1'b1, 3'b000, 32'd0, 0);
    chk("x0_gpr_we", 64'(bus.gpr_we), 64'd0);
    issue(2'd2, 32'd0, 32'h8000_0010, 32'h8000_0080, 32'd0, 5'd1, 1'b1, 3'b000, 32'd0, 0);
    chk("jal_wdata", 64'(bus.gpr_wdata), 64'h8000_0014);
    issue(2'd3, 32'd0, 32'h8000_0080, 32'h8000_0084, 32'hDEAD_BEEF, 5'd3, 1'b1, 3'b000, 32'd0, 0);

    // Backpressure in WB
    or_force = 1'b0;
    issue(2'd0, 32'hCAFE_0001, 32'h8000_0084, 32'h8000_0088, 32'd0, 5'd9, 1'b1, 3'b000, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_gpr_we_once", 64'(bus.gpr_we), 64'd0);
    end
    or_force = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    issue(2'd0, 32'h0000_0042, 32'h8000_0088, 32'h8000_008C, 32'd0, 5'd10, 1'b1, 3'b000, 32'd0, 0);

    // Randomized traffic with random IFU backpressure
    bp_en = 1'b1;
    repeat (40) begin
      sel   = 2'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 31));
      we    = 1'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 3));
      issue(sel, $urandom(), $urandom(), $urandom(), $urandom(), rd, we,
            fmts[$urandom_range(0, 6)], $urandom(), stall);
    end
    bp_en = 1'b0;
    repeat (6) @(negedge clk);

    // Misaligned halfword: no write, still commits, flag becomes sticky
    issue(2'd1, 32'h8000_0303, 32'h8000_0100, 32'h8000_0104, 32'd0, 5'd11, 1'b1, 3'b001, 32'h1234_5678, 0);
    chk("mis_gpr_we", 64'(bus.gpr_we), 64'd0);
    chk("mis_flag", 64'(bus.load_misalign), 64'd1);
    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for load data
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_wb_sel = 2'd1; bus.in_alu_result = 32'h8000_1000;
    bus.in_rd = 5'd9; bus.in_reg_we = 1'b1; bus.in_load_fmt = 3'b010; bus.in_pc = 32'h8000_0200;
    @(negedge clk);
    chk("rstw_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstw_waiting", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstw_async_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #2;
    bus.mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_gpr_we", 64'(bus.gpr_we), 64'd0);
      chk("rstw_commit", 64'(bus.commit_valid), 64'd0);
    end
    chk("rstw_retire_cnt", bus.retire_cnt, 64'd0);
    chk("rstw_out_pc_next", 64'(bus.out_pc_next), 64'h8000_0000);
    chk("rstw_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstw_misalign", 64'(bus.load_misalign), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_wbu_pipe.md
Name: ysyx_25060170_wbu_pipe

Overview:
- Handshaked, multi-cycle write-back stage. It replaces the purely combinational write-back path.
- Accepts one retiring instruction from EXU/LSU and waits for load data when required.
- Formats load data (byte/half/word, signed/unsigned), selects the write-back source, writes the GPR exactly once, then hands the next PC to IFU.
- Maintains a retire counter and a commit strobe for difftest.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width (4 for RV32E).
- CNT_W, 64, retire-counter width.
- RESET_PC, 32'h8000_0000, reset value of out_pc_next.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  EXU has an instruction to retire.
- in_ready  out  1  WBU can accept an instruction.
- in_pc  in  XLEN  PC of the instruction.
- in_alu_result  in  XLEN  ALU result; this is the effective address for loads.
- in_next_pc  in  XLEN  resolved next PC (branch/jal/jalr/pc+4).
- in_rd  in  REG_AW  destination register.
- in_reg_we  in  1  register write enable.
- in_wb_sel  in  2  write-back source: 0 ALU, 1 MEM, 2 PC+4, 3 CSR.
- in_csr_rdata  in  XLEN  CSR old value.
- in_load_fmt  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  word-aligned load data.
- out_valid  out  1  next PC valid to IFU.
- out_ready  in  1  IFU accepts next PC.
- out_pc_next  out  XLEN  next PC.
- gpr_we  out  1  GPR write strobe.
- gpr_waddr  out  REG_AW  GPR write address.
- gpr_wdata  out  XLEN  GPR write data.
- commit_valid  out  1  one-cycle retire pulse.
- commit_pc  out  XLEN  PC of the retired instruction.
- retire_cnt  out  CNT_W  retired-instruction count.
- load_misalign  out  1  sticky misaligned-load flag.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state IDLE, in_ready=1.
  - out_valid=0, out_pc_next=RESET_PC.
  - gpr_we=0, gpr_waddr=0, gpr_wdata=0.
  - commit_valid=0, commit_pc=0, retire_cnt=0, load_misalign=0.
- Reset mid-operation abandons the instruction: no GPR write, no commit, and a later mem_rvalid is ignored.
- All inputs are captured into internal registers on the handshake (in_valid && in_ready).
- State machine:
  - IDLE: in_ready=1. On the handshake, go to WAIT_MEM if in_wb_sel==1, otherwise go to WB.
  - WAIT_MEM: in_ready=0. mem_rvalid is sampled only in this state. On mem_rvalid=1, latch the formatted data and go to WB. Stall indefinitely otherwise.
  - WB: in_ready=0, out_valid=1, out_pc_next=captured in_next_pc. On out_ready=1, return to IDLE.
- GPR write:
  - gpr_we pulses for exactly the first cycle of WB, and only if reg_we==1 and rd!=0.
  - gpr_we must not repeat while WB is stalled by out_ready=0.
- Commit:
  - commit_valid and commit_pc pulse in the first WB cycle.
  - retire_cnt increments by 1 in that same cycle and wraps modulo 2^CNT_W.
- Latency:
  - Non-load: handshake at cycle t; gpr_we, commit_valid and out_valid at t+1; earliest next accept at t+2.
  - Load: mem_rvalid at cycle m; gpr_we at m+1.
- Write-back data:
  - sel 0: alu_result.
  - sel 2: in_pc+4, modulo 2^XLEN.
  - sel 3: csr_rdata.
  - sel 1: the value produced by load formatting.
- Load formatting:
  - Shift mem_rdata right by alu_result[1:0]*8.
  - LB and LH sign-extend bit 7 and bit 15 respectively; LBU and LHU zero-extend.
  - LW uses the word unshifted.
  - Undefined funct3 values write 0.
- Misaligned loads:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, sets load_misalign (sticky until reset).
  - The GPR write is suppressed, but the instruction still commits and the next PC is still delivered.

Decomposition:
- Shared package holds:
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC4, WB_CSR.
  - Load funct3 constants.
  - State enum: IDLE, WAIT_MEM, WB.
- One natural sub-module: ysyx_25060170_load_fmt. It is purely combinational: addr[1:0], fmt and rdata in; data and misalign out.

Test Plan:
- ALU path: handshake with alu_result=0x1234_5678, rd=5, sel=0, next_pc=0x8000_0004 -> next cycle gpr_we=1, waddr=5, wdata=0x1234_5678, out_valid=1, out_pc_next=0x8000_0004, retire_cnt=1.
- Signed byte load: LB, addr[1:0]=2, mem_rdata=0x0080_FF00, mem_rvalid after 3 stall cycles -> in_ready=0 throughout; gpr_wdata=0xFFFF_FF80 one cycle after rvalid. The same case with LBU -> 0x0000_0080.
- Halfword loads: LHU at addr 0x...2 with rdata 0xBEEF_0000 -> 0x0000_BEEF. LH at addr 0x...3 -> load_misalign=1, no gpr_we, commit_valid=1.
- x0 and JAL: rd=0, sel=2, reg_we=1 -> gpr_we stays 0 while commit_valid=1. rd=1, sel=2, pc=0x8000_0010 -> wdata=0x8000_0014.
- Backpressure: hold out_ready=0 for 4 cycles in WB -> gpr_we high for exactly 1 cycle, out_valid held high, in_ready=0. Releasing out_ready returns to IDLE and a new instruction is accepted the next cycle.
- Reset in WAIT_MEM: assert rst=0 mid-wait, then pulse mem_rvalid after release -> no gpr_we, retire_cnt=0, out_pc_next=0x8000_0000, in_ready=1.
